// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words,
// holds the CPU in reset while loading, then serves combinational fetches.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    input  logic [31:0]       instr_addr,
    output logic [31:0]       instr,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        ST_CNT_HI = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_e            state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              cpu_rst_q, cpu_rst_d;

    logic              accept_s;
    logic [15:0]       n_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [31:0]       wdata_s;
    logic [ADDR_W:0]   words_inc_s;
    logic              unused_addr_s;

    logic [31:0]       mem_q [DEPTH];

    assign rx_ready      = (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO) || (state_q == ST_DATA);
    assign accept_s      = rx_valid && rx_ready;
    assign n_s           = {cnt_hi_q, rx_data};
    assign words_inc_s   = words_q + (ADDR_W+1)'(1);
    assign load_done     = (state_q == ST_RUN);
    assign load_error    = (state_q == ST_ERROR);
    assign cpu_rst       = cpu_rst_q;
    assign words_loaded  = words_q;
    assign unused_addr_s = ^instr_addr[1:0];

    // Next-state, stream parsing and RAM write strobe.
    always_comb begin
        state_d    = state_q;
        cnt_hi_d   = cnt_hi_q;
        n_d        = n_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        words_d    = words_q;
        we_s       = 1'b0;
        waddr_s    = words_q[ADDR_W-1:0];
        wdata_s    = {asm_q, rx_data};
        case (state_q)
            ST_CNT_HI: begin
                if (accept_s) begin
                    cnt_hi_d = rx_data;
                    state_d  = ST_CNT_LO;
                end else begin
                    state_d = ST_CNT_HI;
                end
            end
            ST_CNT_LO: begin
                if (!accept_s) begin
                    state_d = ST_CNT_LO;
                end else if (n_s == 16'd0) begin
                    state_d = ST_RUN;
                end else if ({1'b0, n_s} > DEPTH_L) begin
                    state_d = ST_ERROR;
                end else begin
                    n_d        = n_s[ADDR_W:0];
                    byte_cnt_d = 2'd0;
                    words_d    = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    asm_d      = {asm_q[15:0], rx_data};
                    // The fourth byte completes the word and is written on this same edge.
                    if (byte_cnt_q == 2'd3) begin
                        we_s    = 1'b1;
                        words_d = words_inc_s;
                        if (words_inc_s == n_q) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_d = ST_CNT_HI;
                    words_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_CNT_HI;
            end
        endcase
        cpu_rst_d = (state_d != ST_RUN);
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CNT_HI;
            cnt_hi_q   <= 8'd0;
            n_q        <= '0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            words_q    <= '0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_hi_q   <= cnt_hi_d;
            n_q        <= n_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            words_q    <= words_d;
            cpu_rst_q  <= cpu_rst_d;
        end
    end

    // Instruction RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    // Combinational fetch; out-of-range addresses and non-RUN states return NOP.
    always_comb begin
        instr = 32'h0;
        if ((state_q == ST_RUN) && (instr_addr[31:ADDR_W+2] == '0)) begin
            instr = mem_q[instr_addr[ADDR_W+1:2]];
        end else begin
            instr = 32'h0;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expectations, a negedge monitor compares.
module tb_imem_loader;

    localparam int K_INSTR = 0;
    localparam int K_CRST  = 1;
    localparam int K_DONE  = 2;
    localparam int K_ERR   = 3;
    localparam int K_RDY   = 4;
    localparam int K_WORDS = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        reload;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        cpu_rst;
    logic        load_done;
    logic        load_error;
    logic [8:0]  words_loaded;

    int          checks = 0;
    int          errors = 0;
    int          kq[$];
    logic [31:0] eq[$];
    logic [7:0]  stream[$];

    int          mk;
    logic [31:0] me;
    logic [31:0] ma;
    string       mn;
    logic [7:0]  last_b;

    imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .reload(reload), .instr_addr(instr_addr), .instr(instr), .cpu_rst(cpu_rst),
        .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Monitor: drain every queued expectation at the falling edge.
    always @(negedge clk) begin
        while (kq.size() > 0) begin
            mk = kq.pop_front();
            me = eq.pop_front();
            case (mk)
                K_INSTR: begin ma = instr;                 mn = "instr";        end
                K_CRST:  begin ma = {31'd0, cpu_rst};      mn = "cpu_rst";      end
                K_DONE:  begin ma = {31'd0, load_done};    mn = "load_done";    end
                K_ERR:   begin ma = {31'd0, load_error};   mn = "load_error";   end
                K_RDY:   begin ma = {31'd0, rx_ready};     mn = "rx_ready";     end
                K_WORDS: begin ma = {23'd0, words_loaded}; mn = "words_loaded"; end
                default: begin ma = 32'hxxxxxxxx;          mn = "unknown";      end
            endcase
            checks++;
            if (ma !== me) begin
                errors++;
                $display("FAIL %s actual=%h expected=%h at %0t", mn, ma, me, $time);
            end
        end
    end

    task automatic check_now(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, a, e, $time);
        end
    endtask

    task automatic expect_v(input int k, input logic [31:0] e);
        kq.push_back(k);
        eq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input logic crst, input logic done, input logic err,
                          input logic rdy, input logic [31:0] words);
        expect_v(K_CRST, {31'd0, crst});
        expect_v(K_DONE, {31'd0, done});
        expect_v(K_ERR, {31'd0, err});
        expect_v(K_RDY, {31'd0, rdy});
        expect_v(K_WORDS, words);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] e);
        instr_addr = a;
        expect_v(K_INSTR, e);
        tick();
    endtask

    task automatic add_count(input logic [15:0] n);
        stream.push_back(n[15:8]);
        stream.push_back(n[7:0]);
    endtask

    task automatic add_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    // Gapped mode inserts an idle cycle with junk data before each byte; one gap also pulses reload.
    task automatic send(input bit gapped, input bit chk);
        for (int i = 0; i < stream.size(); i++) begin
            if (gapped) begin
                rx_valid = 1'b0;
                rx_data  = 8'hAA;
                reload   = (i == 3);
                tick();
                reload   = 1'b0;
            end
            rx_valid = 1'b1;
            rx_data  = stream[i];
            if (chk) begin
                expect_v(K_RDY, 32'd1);
                expect_v(K_CRST, 32'd1);
            end
            tick();
        end
        rx_valid = 1'b0;
        stream.delete();
    endtask

    initial begin
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        reload     = 1'b0;
        instr_addr = 32'h0;
        tick();
        check_now("reset_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_now("reset_words_loaded", {23'd0, words_loaded}, 32'd0);
        status(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        expect_v(K_INSTR, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Continuous two-word program
        add_count(16'h0002);
        add_word(32'h20080005);
        add_word(32'h20090007);
        send(1'b0, 1'b1);
        status(1'b0, 1'b1, 1'b0, 1'b0, 32'd2);
        fetch(32'h0, 32'h20080005);
        fetch(32'h4, 32'h20090007);
        fetch(32'h6, 32'h20090007);
        fetch(32'h3, 32'h20080005);
        fetch(32'h400, 32'h0);

        // Reload from RUN with a one-word program
        pulse_reload();
        instr_addr = 32'h0;
        status(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        expect_v(K_INSTR, 32'h0);
        tick();
        add_count(16'h0001);
        add_word(32'hDEADBEEF);
        send(1'b0, 1'b0);
        status(1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
        fetch(32'h0, 32'hDEADBEEF);
        fetch(32'h4, 32'h20090007);

        // Gapped stream restores the original program
        pulse_reload();
        add_count(16'h0002);
        add_word(32'h20080005);
        add_word(32'h20090007);
        send(1'b1, 1'b0);
        status(1'b0, 1'b1, 1'b0, 1'b0, 32'd2);
        fetch(32'h0, 32'h20080005);
        fetch(32'h4, 32'h20090007);

        // Empty program
        pulse_reload();
        add_count(16'h0000);
        send(1'b0, 1'b1);
        status(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        fetch(32'h0, 32'h20080005);

        // Reset after five data bytes
        pulse_reload();
        add_count(16'h0002);
        stream.push_back(8'h11);
        stream.push_back(8'h22);
        stream.push_back(8'h33);
        stream.push_back(8'h44);
        stream.push_back(8'h55);
        send(1'b0, 1'b0);
        status(1'b1, 1'b0, 1'b0, 1'b1, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        status(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        rst = 1'b0;
        add_count(16'h0001);
        add_word(32'hCAFEBABE);
        send(1'b0, 1'b0);
        status(1'b0, 1'b1, 1'b0, 1'b0, 32'd1);
        fetch(32'h0, 32'hCAFEBABE);
        fetch(32'h4, 32'h20090007);

        // Full RAM, final byte held back to observe the edge into RUN
        pulse_reload();
        add_count(16'h0100);
        for (int i = 0; i < 256; i++) begin
            add_word(32'(i));
        end
        last_b = stream.pop_back();
        send(1'b0, 1'b0);
        status(1'b1, 1'b0, 1'b0, 1'b1, 32'd255);
        tick();
        stream.push_back(last_b);
        send(1'b0, 1'b0);
        status(1'b0, 1'b1, 1'b0, 1'b0, 32'd256);
        fetch(32'h3FC, 32'h000000FF);
        fetch(32'h200, 32'h00000080);
        fetch(32'h004, 32'h00000001);
        fetch(32'h400, 32'h0);
        fetch(32'hFFFFFFFC, 32'h0);

        // Overflow count is sticky
        pulse_reload();
        add_count(16'h0101);
        send(1'b0, 1'b1);
        status(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        fetch(32'h0, 32'h0);
        pulse_reload();
        status(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        tick();
        rx_valid = 1'b0;
        status(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        expect_v(K_INSTR, 32'h0);
        tick();
        tick();
        check_now("sticky_load_error", {31'd0, load_error}, 32'd1);
        check_now("sticky_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_now("sticky_rx_ready", {31'd0, rx_ready}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory block on the CPU's fetch side, directly upstream of the fetch stage.
- Receives a program as a byte stream over a valid/ready handshake, assembles 32-bit words and writes them into an internal word RAM.
- Holds the CPU in reset while loading.
- Once loaded, serves the CPU's `instr_addr` with a combinational `instr` read, which matches the fetch stage's same-cycle instruction expectation.

Parameters:
- DEPTH, 256: instruction RAM size in 32-bit words; a power of two, at least 2.
- ADDR_W, 8: word-index width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  incoming program byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- reload  in  1  single-cycle request to start a new load; honoured only in RUN.
- instr_addr  in  32  CPU fetch byte address.
- instr  out  32  instruction word to the CPU.
- cpu_rst  out  1  reset to the CPU; high while not in RUN.
- load_done  out  1  high in RUN.
- load_error  out  1  high in ERROR.
- words_loaded  out  ADDR_W+1  number of words written in the current load.

Behaviour:
- Handshake and reset:
  - A byte is accepted on any rising edge where rx_valid && rx_ready.
  - rx_data is sampled only on accepted cycles.
  - rx_valid may drop at any time without effect.
  - Reset is clock and reset as decided: one clock; reset is asynchronous and active-high.
  - Reset values: state=CNT_HI, cpu_rst=1, load_done=0, load_error=0, words_loaded=0, byte counter=0, word count register=0.
  - RAM contents are not reset.
- Stream format, all fields big-endian:
  - count_hi, then count_lo, forming the 16-bit word count N.
  - Then N words of 4 bytes each; the first byte is bits [31:24].
- FSM:
  - CNT_HI: rx_ready=1. On accept, store the high byte and go to CNT_LO.
  - CNT_LO: rx_ready=1. On accept, form N.
    - N==0: go to RUN.
    - N>DEPTH: go to ERROR.
    - Otherwise: go to DATA with word index=0 and byte counter=0.
  - DATA: rx_ready=1. Each accepted byte shifts into the assembly register and increments the byte counter (0..3, wraps).
    - On the 4th byte, write the full word (including the byte just accepted) to RAM[word index] on that same edge.
    - Then increment the word index and words_loaded.
    - If the word index reaches N, go to RUN.
  - RUN: rx_ready=0. If reload==1, go to CNT_HI, clear words_loaded, and set cpu_rst=1 on the next edge.
  - ERROR: rx_ready=0 and load_error=1. Sticky until rst; reload is ignored.
- cpu_rst:
  - Registered output: cpu_rst = (next_state != RUN).
  - It falls on the edge that accepts the final data byte, or the count_lo byte when N=0.
  - It rises on the edge that takes reload.
- Fetch read:
  - Word index = instr_addr[ADDR_W+1:2]; instr_addr[1:0] is ignored.
  - If instr_addr[31:ADDR_W+2] != 0, instr = 32'h0 (NOP).
  - When not in RUN, instr = 32'h0.
  - Otherwise instr = RAM[index], combinational from the current RAM contents.
  - Words beyond N keep their previous (undefined) contents; the program is responsible for not fetching them.
- Boundary conditions:
  - N==DEPTH is legal and fills the RAM exactly.
  - Asserting rst mid-DATA aborts the load immediately; the partially written RAM is kept, and the next stream restarts at CNT_HI.
  - reload during CNT_HI, CNT_LO or DATA is ignored.

Test Plan:
- Load program, count 0x0002, words 0x20080005 and 0x20090007 with rx_valid held high:
  - rx_ready high for 10 cycles.
  - cpu_rst falls on the 10th accepting edge.
  - load_done=1 and words_loaded=2.
  - instr_addr 0x0 gives 0x20080005, 0x4 gives 0x20090007, 0x6 gives 0x20090007, 0x400 gives 0x0.
- Gapped stream: same program with rx_valid low on alternate cycles → identical RAM contents and final state; no byte is double-counted.
- Empty and overflow counts:
  - count 0x0000 → RUN right after the 2nd byte, words_loaded=0.
  - count 0x0101 (DEPTH+1) → load_error=1, rx_ready=0, cpu_rst stays 1.
  - A later reload pulse has no effect.
- Reset mid-load: assert rst after 5 data bytes →
  - cpu_rst=1 and words_loaded=0 asynchronously.
  - A fresh 1-word stream then loads correctly, and word 0 holds the new value.
- Reload in RUN: pulse reload → cpu_rst=1 the next cycle, rx_ready=1, instr=0; a new 1-word program 0xDEADBEEF is then fetched at address 0.
- Full RAM: count 0x0100 with word i = i → RAM[255]=0xFF and RUN is entered after 1026 accepted bytes.
